multicycle_control: RTL
=======================

# multicycle_control

Main sequencing FSM for the multi-cycle RV32I core. It decodes the 7-bit opcode held in the instruction register and steps the shared datapath (single ALU, single memory port) through fetch, decode, execute, memory and write-back states. It drives the 3-bit `aluop` into ALU_control, and ALU_control resolves the final ALU operation from funct3/funct7. It also stalls on a memory ready handshake and counts retired instructions.

## Interface
- CNT_WIDTH, 32, width of the retired-instruction counter.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  instr[6:0] from the instruction register; valid from DECODE onward.
- mem_ready  in  1  memory has completed the current access this cycle.
- mem_req  out  1  memory access request; held high until mem_ready.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req is high.
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC write.
- pc_write_cond  out  1  PC write qualified by the datapath branch-taken flag.
- pc_src  out  2  next-PC select: 00 = ALU result, 01 = ALUOut.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = rs1, 10 = old PC (PC of the current instruction).
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = constant 4, 10 = immediate.
- aluop  out  3  to ALU_control: 000 = R-type (funct3/funct7), 001 = I-type ALU (funct3), 010 = branch compare (funct3), 011 = add.
- reg_write  out  1  register file write enable.
- wb_sel  out  2  write-back data: 00 = ALUOut, 01 = MDR, 10 = PC (link).
- illegal_instr  out  1  one-cycle pulse on an unsupported opcode.
- state  out  4  current state encoding, for debug and verification.
- retired  out  CNT_WIDTH  retired-instruction count.

## Operation
- Moore FSM. Outputs are combinational from `state`, except `ir_write` and the FETCH `pc_write`, which are gated by `mem_ready`.
- Any output not listed for a state is 0; `aluop` defaults to 011.
- State encodings:
  - 0 FETCH: mem_req=1, i_or_d=0, src_a=00, src_b=01, aluop=011, pc_src=00, ir_write=pc_write=mem_ready. Stay while !mem_ready, else go to DECODE.
  - 1 DECODE: src_a=10, src_b=10, aluop=011 (branch/JAL target into ALUOut). Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → MEM_ADDR
    - 1100011 → BRANCH
    - 1101111 → JAL
    - any other opcode → ILLEGAL
  - 2 MEM_ADDR: src_a=01, src_b=10, aluop=011. Go to MEM_RD if opcode=0000011, else MEM_WR.
  - 3 MEM_RD: mem_req=1, i_or_d=1, mem_we=0. Stay while !mem_ready, else go to LOAD_WB.
  - 4 LOAD_WB: reg_write=1, wb_sel=01, then FETCH.
  - 5 MEM_WR: mem_req=1, i_or_d=1, mem_we=1. Stay while !mem_ready, else go to FETCH.
  - 6 EXEC_R: src_a=01, src_b=00, aluop=000, then ALU_WB.
  - 7 EXEC_I: src_a=01, src_b=10, aluop=001, then ALU_WB.
  - 8 ALU_WB: reg_write=1, wb_sel=00, then FETCH.
  - 9 BRANCH: src_a=01, src_b=00, aluop=010, pc_write_cond=1, pc_src=01, then FETCH.
  - 10 JAL: pc_write=1, pc_src=01, reg_write=1, wb_sel=10, then FETCH.
  - 11 ILLEGAL: illegal_instr=1, then FETCH.
  - Encodings 12–15 are unreachable and map to FETCH on the next edge.
- `opcode` is sampled only in DECODE and MEM_ADDR. `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR.
- `retired` increments by 1 on the clock edge leaving any of:
  - LOAD_WB, ALU_WB, BRANCH, JAL;
  - MEM_WR when mem_ready=1.
- `retired` wraps from 2^CNT_WIDTH−1 to 0. ILLEGAL does not retire.

## Timing
- Reset: while rst_n=0, state=FETCH (0) and retired=0 asynchronously. Outputs take their FETCH values; the datapath PC is itself reset, so the FETCH PC write is harmless.
- Reset asserted mid-access abandons the request. After release, the FSM refetches from FETCH on the first rising edge.
- Latency with zero wait states (mem_ready high on the first request cycle), counted from entry to FETCH:
  - R/I: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch, JAL, illegal: 3 cycles
- Each cycle with mem_req=1 and mem_ready=0 adds one cycle. mem_req, mem_we and i_or_d stay stable throughout the stall.
- Handshake: an access completes on the edge where mem_req=1 and mem_ready=1. mem_req is never dropped before completion.
- FETCH back-to-back: FETCH is re-entered on the cycle immediately after a terminal state, with no idle cycle.

## Test plan
- Reset then R-type: rst_n low 3 cycles, then high. Check state=0, retired=0, mem_req=1. With opcode=0110011 and mem_ready=1, expect state sequence 0,1,6,8,0; aluop=000 in state 6; reg_write=1 with wb_sel=00 in state 8; retired=1.
- Load with 2 wait states: opcode=0000011, mem_ready low 2 cycles in MEM_RD. Expect sequence 0,1,2,3,3,3,4,0. mem_req, i_or_d=1 and mem_we=0 held stable across the stall; wb_sel=01 in state 4.
- Store, branch and JAL: opcode=0100011 gives 0,1,2,5,0 with mem_we=1. 1100011 gives 0,1,9,0 with aluop=010 and pc_write_cond=1. 1101111 gives 0,1,10,0 with wb_sel=10 and pc_write=1. retired increases by 3 in total.
- Illegal opcode 1111111: expect 0,1,11,0, illegal_instr high exactly 1 cycle, retired unchanged.
- Async reset during an MEM_WR stall: rst_n dropped mid-cycle. state goes to 0 and retired to 0 before the next clock edge; normal fetch resumes after release.
- Counter wrap: CNT_WIDTH=4, run 16 ALU instructions; retired reaches 15, then reads 0.

Source files
------------

// File: rtl/multicycle_control_if.sv
// Control bundle between the multi-cycle sequencer and the shared datapath/memory port.
// Latency: none, wires only.
// Backpressure: mem_ready from the memory side stalls the sequencer while mem_req is high.
interface multicycle_control_if #(
  parameter int CNT_WIDTH = 32
) ();

  // Inputs to the sequencer
  logic [6:0]           opcode;
  logic                 mem_ready;

  // Memory port control
  logic                 mem_req;
  logic                 mem_we;
  logic                 i_or_d;

  // Datapath steering
  logic                 ir_write;
  logic                 pc_write;
  logic                 pc_write_cond;
  logic [1:0]           pc_src;
  logic [1:0]           alu_src_a;
  logic [1:0]           alu_src_b;
  logic [2:0]           aluop;
  logic                 reg_write;
  logic [1:0]           wb_sel;

  // Status and debug
  logic                 illegal_instr;
  logic [3:0]           state;
  logic [CNT_WIDTH-1:0] retired;

  // Sequencer side
  modport master (
    input  opcode, mem_ready,
    output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
           pc_src, alu_src_a, alu_src_b, aluop, reg_write, wb_sel,
           illegal_instr, state, retired
  );

  // Datapath / memory side
  modport slave (
    output opcode, mem_ready,
    input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_write_cond,
           pc_src, alu_src_a, alu_src_b, aluop, reg_write, wb_sel,
           illegal_instr, state, retired
  );

endinterface

// File: rtl/multicycle_control.sv
// Moore sequencing FSM for the multi-cycle RV32I core; counts retired instructions.
// Latency: R/I 4, load 5, store 4, branch/JAL/illegal 3 cycles with zero wait states.
// Backpressure: FETCH, MEM_RD and MEM_WR hold with stable request signals until mem_ready.
module multicycle_control #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.master  ctl
);

  // State encodings are visible on the debug port, so keep them fixed
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_LOAD_WB  = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC_R   = 4'd6;
  localparam logic [3:0] S_EXEC_I   = 4'd7;
  localparam logic [3:0] S_ALU_WB   = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_ILLEGAL  = 4'd11;

  // Supported major opcodes
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALU operation hints for ALU_control
  localparam logic [2:0] ALUOP_R   = 3'b000;
  localparam logic [2:0] ALUOP_I   = 3'b001;
  localparam logic [2:0] ALUOP_BR  = 3'b010;
  localparam logic [2:0] ALUOP_ADD = 3'b011;

  logic [3:0]           r_state;
  logic [3:0]           w_next_state;
  logic [CNT_WIDTH-1:0] r_retired;
  logic                 w_retire;

  logic                 w_mem_req;
  logic                 w_mem_we;
  logic                 w_i_or_d;
  logic                 w_ir_write;
  logic                 w_pc_write;
  logic                 w_pc_write_cond;
  logic [1:0]           w_pc_src;
  logic [1:0]           w_alu_src_a;
  logic [1:0]           w_alu_src_b;
  logic [2:0]           w_aluop;
  logic                 w_reg_write;
  logic [1:0]           w_wb_sel;
  logic                 w_illegal_instr;

  // Next-state selection; opcode only matters in DECODE and MEM_ADDR,
  // mem_ready only in the three memory-access states
  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:    w_next_state = ctl.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (ctl.opcode)
          OP_R:      w_next_state = S_EXEC_R;
          OP_I:      w_next_state = S_EXEC_I;
          OP_LOAD:   w_next_state = S_MEM_ADDR;
          OP_STORE:  w_next_state = S_MEM_ADDR;
          OP_BRANCH: w_next_state = S_BRANCH;
          OP_JAL:    w_next_state = S_JAL;
          default:   w_next_state = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: w_next_state = (ctl.opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next_state = ctl.mem_ready ? S_LOAD_WB : S_MEM_RD;
      S_LOAD_WB:  w_next_state = S_FETCH;
      S_MEM_WR:   w_next_state = ctl.mem_ready ? S_FETCH : S_MEM_WR;
      S_EXEC_R:   w_next_state = S_ALU_WB;
      S_EXEC_I:   w_next_state = S_ALU_WB;
      S_ALU_WB:   w_next_state = S_FETCH;
      S_BRANCH:   w_next_state = S_FETCH;
      S_JAL:      w_next_state = S_FETCH;
      S_ILLEGAL:  w_next_state = S_FETCH;
      default:    w_next_state = S_FETCH;  // 12-15 recover to FETCH
    endcase
  end

  // Datapath controls decoded from the current state; only the FETCH
  // IR/PC writes look at mem_ready so they fire once, on completion
  always_comb begin
    w_mem_req       = 1'b0;
    w_mem_we        = 1'b0;
    w_i_or_d        = 1'b0;
    w_ir_write      = 1'b0;
    w_pc_write      = 1'b0;
    w_pc_write_cond = 1'b0;
    w_pc_src        = 2'b00;
    w_alu_src_a     = 2'b00;
    w_alu_src_b     = 2'b00;
    w_aluop         = ALUOP_ADD;
    w_reg_write     = 1'b0;
    w_wb_sel        = 2'b00;
    w_illegal_instr = 1'b0;
    case (r_state)
      S_FETCH: begin
        // Fetch at PC and compute PC+4 in the same cycle
        w_mem_req   = 1'b1;
        w_alu_src_b = 2'b01;
        w_ir_write  = ctl.mem_ready;
        w_pc_write  = ctl.mem_ready;
      end
      S_DECODE: begin
        // Speculative branch/JAL target (old PC + imm) into ALUOut
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b10;
      end
      S_MEM_ADDR: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
      end
      S_MEM_RD: begin
        w_mem_req = 1'b1;
        w_i_or_d  = 1'b1;
      end
      S_LOAD_WB: begin
        w_reg_write = 1'b1;
        w_wb_sel    = 2'b01;
      end
      S_MEM_WR: begin
        w_mem_req = 1'b1;
        w_i_or_d  = 1'b1;
        w_mem_we  = 1'b1;
      end
      S_EXEC_R: begin
        w_alu_src_a = 2'b01;
        w_aluop     = ALUOP_R;
      end
      S_EXEC_I: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_aluop     = ALUOP_I;
      end
      S_ALU_WB: begin
        w_reg_write = 1'b1;
      end
      S_BRANCH: begin
        // ALU compares rs1/rs2; taken flag qualifies the PC write from ALUOut
        w_alu_src_a     = 2'b01;
        w_aluop         = ALUOP_BR;
        w_pc_write_cond = 1'b1;
        w_pc_src        = 2'b01;
      end
      S_JAL: begin
        w_pc_write  = 1'b1;
        w_pc_src    = 2'b01;
        w_reg_write = 1'b1;
        w_wb_sel    = 2'b10;
      end
      S_ILLEGAL: begin
        w_illegal_instr = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // An instruction retires on the edge leaving its last state
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      S_LOAD_WB, S_ALU_WB, S_BRANCH, S_JAL: w_retire = 1'b1;
      S_MEM_WR:                            w_retire = ctl.mem_ready;
      default:                             w_retire = 1'b0;
    endcase
  end

  // State register; reset abandons any in-flight access
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Retired-instruction counter, wraps naturally at its width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (w_retire) begin
      r_retired <= r_retired + CNT_WIDTH'(1);
    end
  end

  assign ctl.mem_req       = w_mem_req;
  assign ctl.mem_we        = w_mem_we;
  assign ctl.i_or_d        = w_i_or_d;
  assign ctl.ir_write      = w_ir_write;
  assign ctl.pc_write      = w_pc_write;
  assign ctl.pc_write_cond = w_pc_write_cond;
  assign ctl.pc_src        = w_pc_src;
  assign ctl.alu_src_a     = w_alu_src_a;
  assign ctl.alu_src_b     = w_alu_src_b;
  assign ctl.aluop         = w_aluop;
  assign ctl.reg_write     = w_reg_write;
  assign ctl.wb_sel        = w_wb_sel;
  assign ctl.illegal_instr = w_illegal_instr;
  assign ctl.state         = r_state;
  assign ctl.retired       = r_retired;

endmodule
